// File: rtl/sram_axi_master_pkg.sv
// Shared AXI3 field widths, fixed field values and FSM state encodings for
// the SRAM-to-AXI initiator bridge.
package sram_axi_master_pkg;

    localparam int ID_W    = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int STRB_W  = 4;
    localparam int LEN_W   = 4;
    localparam int SIZE_W  = 3;
    localparam int BURST_W = 2;
    localparam int LOCK_W  = 2;
    localparam int CACHE_W = 4;
    localparam int PROT_W  = 3;
    localparam int RESP_W  = 2;

    localparam logic [BURST_W-1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AR   = 3'd1;
    localparam logic [2:0] S_R    = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_B    = 3'd4;
    localparam logic [2:0] S_RESP = 3'd5;

    // SRAM size code (0=byte, 1=half, 2=word) maps directly onto AxSIZE.
    function automatic logic [SIZE_W-1:0] axi_size(input logic [1:0] size);
        return {1'b0, size};
    endfunction

endpackage

// File: rtl/sram_axi_master.sv
// SRAM-style instruction/data request ports to single-beat AXI3 transactions,
// one outstanding at a time, data port ahead of instruction port.
module sram_axi_master
    import sram_axi_master_pkg::*;
#(
    parameter logic [ID_W-1:0] INST_ID = 4'd0,
    parameter logic [ID_W-1:0] DATA_ID = 4'd1
) (
    input  logic                aclk,
    input  logic                aresetn,

    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,

    input  logic                data_req,
    input  logic                data_wr,
    input  logic [1:0]          data_size,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [STRB_W-1:0]   data_wstrb,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,

    output logic [ID_W-1:0]     arid,
    output logic [ADDR_W-1:0]   araddr,
    output logic [LEN_W-1:0]    arlen,
    output logic [SIZE_W-1:0]   arsize,
    output logic [BURST_W-1:0]  arburst,
    output logic [LOCK_W-1:0]   arlock,
    output logic [CACHE_W-1:0]  arcache,
    output logic [PROT_W-1:0]   arprot,
    output logic                arvalid,
    input  logic                arready,

    input  logic [ID_W-1:0]     rid,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [RESP_W-1:0]   rresp,
    input  logic                rlast,
    input  logic                rvalid,
    output logic                rready,

    output logic [ID_W-1:0]     awid,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [LEN_W-1:0]    awlen,
    output logic [SIZE_W-1:0]   awsize,
    output logic [BURST_W-1:0]  awburst,
    output logic [LOCK_W-1:0]   awlock,
    output logic [CACHE_W-1:0]  awcache,
    output logic [PROT_W-1:0]   awprot,
    output logic                awvalid,
    input  logic                awready,

    output logic [ID_W-1:0]     wid,
    output logic [DATA_W-1:0]   wdata,
    output logic [STRB_W-1:0]   wstrb,
    output logic                wlast,
    output logic                wvalid,
    input  logic                wready,

    input  logic [ID_W-1:0]     bid,
    input  logic [RESP_W-1:0]   bresp,
    input  logic                bvalid,
    output logic                bready,

    output logic [2:0]          dbg_state
);

    // Handshakes: a beat transfers on a rising clock edge where both valid
    // and ready are high; valid and payload stay stable until that edge.

    logic [2:0]         state;
    logic [ID_W-1:0]    id_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [1:0]         size_q;
    logic [STRB_W-1:0]  wstrb_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               aw_done;
    logic               w_done;
    logic               unused_inputs;

    assign unused_inputs = ^{rid, rresp, bid, bresp};

    // Request acceptance is gated by reset so nothing is acknowledged while held.
    assign data_addr_ok = aresetn && (state == S_IDLE) && data_req;
    assign inst_addr_ok = aresetn && (state == S_IDLE) && !data_req && inst_req;

    assign arvalid = (state == S_AR);
    assign rready  = (state == S_R);
    assign awvalid = (state == S_WR) && !aw_done;
    assign wvalid  = (state == S_WR) && !w_done;
    assign bready  = (state == S_B);

    assign inst_data_ok = (state == S_RESP) && (id_q == INST_ID);
    assign data_data_ok = (state == S_RESP) && (id_q == DATA_ID);

    assign arid    = id_q;
    assign araddr  = addr_q;
    assign arlen   = '0;
    assign arsize  = axi_size(size_q);
    assign arburst = AXI_BURST_INCR;
    assign arlock  = '0;
    assign arcache = '0;
    assign arprot  = '0;

    assign awid    = id_q;
    assign awaddr  = addr_q;
    assign awlen   = '0;
    assign awsize  = axi_size(size_q);
    assign awburst = AXI_BURST_INCR;
    assign awlock  = '0;
    assign awcache = '0;
    assign awprot  = '0;

    assign wid     = id_q;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign wlast   = 1'b1;

    assign dbg_state = state;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= S_IDLE;
            id_q       <= '0;
            addr_q     <= '0;
            size_q     <= '0;
            wstrb_q    <= '0;
            wdata_q    <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            inst_rdata <= '0;
            data_rdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (data_req) begin
                        id_q    <= DATA_ID;
                        addr_q  <= data_addr;
                        size_q  <= data_size;
                        wstrb_q <= data_wstrb;
                        wdata_q <= data_wdata;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        state   <= data_wr ? S_WR : S_AR;
                    end else if (inst_req) begin
                        id_q   <= INST_ID;
                        addr_q <= inst_addr;
                        size_q <= 2'd2;
                        state  <= S_AR;
                    end
                end
                S_AR: begin
                    if (arready) state <= S_R;
                end
                S_R: begin
                    if (rvalid && rlast) begin
                        if (id_q == INST_ID) inst_rdata <= rdata;
                        else                 data_rdata <= rdata;
                        state <= S_RESP;
                    end
                end
                S_WR: begin
                    // AW and W complete independently; both may land in one cycle.
                    if (awvalid && awready) aw_done <= 1'b1;
                    if (wvalid && wready)   w_done  <= 1'b1;
                    if ((aw_done || awready) && (w_done || wready)) state <= S_B;
                end
                S_B: begin
                    if (bvalid) state <= S_RESP;
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
